// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding
// and the sizing rule for bit counters.
package arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Wide enough to hold the value 'width' itself, so a count of WIDTH never wraps.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/fs_bit.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
module fs_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin (mod 2^WIDTH), LSB first, one bit
// per clock through a single fs_bit cell and a borrow flip-flop.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Borrow
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_res;
   logic [WIDTH-1:0]   w_res_nxt;
   logic               r_bor;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_d;
   logic               w_bout;
   logic               w_accept;
   logic               w_last;

   fs_bit u_fs_bit (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .bin  (r_bor),
      .d    (w_d),
      .bout (w_bout)
   );

   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   // New difference bit enters at the MSB so the word is aligned after WIDTH shifts.
   always_comb begin
      w_res_nxt            = r_res >> 1;
      w_res_nxt[WIDTH-1]   = w_d;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_bor   <= 1'b0;
         r_cnt   <= '0;
         Diff    <= '0;
         Borrow  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_a   <= A;
            r_b   <= B;
            r_bor <= Bin;
            r_cnt <= '0;
         end else if (r_state == ST_RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_bor <= w_bout;
            r_res <= w_res_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            // Result outputs move only on the completion edge, never bit by bit.
            if (w_last) begin
               Diff   <= w_res_nxt;
               Borrow <= w_bout;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

   typedef struct {
      logic [7:0] diff;
      logic       bor;
      int         cyc;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       start8, start1;
   logic [7:0] A8, B8;
   logic [0:0] A1, B1;
   logic       Bin8, Bin1;
   logic       busy8, done8, Borrow8;
   logic       busy1, done1, Borrow1;
   logic [7:0] Diff8;
   logic [0:0] Diff1;

   int   cyc;
   int   n_chk;
   int   n_fail;
   exp_t q8[$];
   exp_t q1[$];

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8), .Bin(Bin8),
      .busy(busy8), .done(done8), .Diff(Diff8), .Borrow(Borrow8)
   );

   serial_subtractor #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1), .Bin(Bin1),
      .busy(busy1), .done(done1), .Diff(Diff1), .Borrow(Borrow1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops an expectation whenever either DUT pulses done.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && done8 === 1'b1) begin
            if (q8.size() == 0) begin
               chk("done8_unexpected", 64'd1, 64'd0);
            end else begin
               e = q8.pop_front();
               chk("diff8", 64'(Diff8), 64'(e.diff));
               chk("borrow8", 64'(Borrow8), 64'(e.bor));
               chk("latency8", 64'(cyc), 64'(e.cyc));
            end
         end
         if (!rst && done1 === 1'b1) begin
            if (q1.size() == 0) begin
               chk("done1_unexpected", 64'd1, 64'd0);
            end else begin
               e = q1.pop_front();
               chk("diff1", 64'(Diff1), 64'(e.diff[0]));
               chk("borrow1", 64'(Borrow1), 64'(e.bor));
               chk("latency1", 64'(cyc), 64'(e.cyc));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input bit push, input logic [7:0] ed, input logic eb);
      exp_t e;
      A8 = a; B8 = b; Bin8 = bin; start8 = 1'b1;
      if (push) begin
         e.diff = ed; e.bor = eb; e.cyc = cyc + 9;
         q8.push_back(e);
      end
      step();
      start8 = 1'b0;
   endtask

   task automatic go1(input logic a, input logic b, input logic bin,
                      input logic ed, input logic eb);
      exp_t e;
      A1 = a; B1 = b; Bin1 = bin; start1 = 1'b1;
      e.diff = {7'd0, ed}; e.bor = eb; e.cyc = cyc + 2;
      q1.push_back(e);
      step();
      start1 = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         step();
         if (q8.size() == 0 && q1.size() == 0 && !busy8 && !done8 && !busy1 && !done1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk({nm, "_timeout"}, 64'd1, 64'd0);
   endtask

   initial begin
      logic [7:0] tbl_d;
      logic [7:0] tbl_b;
      logic [2:0] idx;
      cyc = 0; n_chk = 0; n_fail = 0;
      rst = 1'b1;
      start8 = 1'b0; A8 = '0; B8 = '0; Bin8 = 1'b0;
      start1 = 1'b0; A1 = '0; B1 = '0; Bin1 = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();

      chk("rst_busy8", 64'(busy8), 64'd0);
      chk("rst_done8", 64'(done8), 64'd0);
      chk("rst_diff8", 64'(Diff8), 64'd0);
      chk("rst_borrow8", 64'(Borrow8), 64'd0);
      chk("rst_busy1", 64'(busy1), 64'd0);

      // 0x5A - 0x3C with cycle-accurate busy/done profile
      go8(8'h5A, 8'h3C, 1'b0, 1'b1, 8'h1E, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk("busy_run", 64'(busy8), 64'd1);
      end
      @(negedge clk);
      chk("busy_done_cycle", 64'(busy8), 64'd0);
      chk("done_pulse", 64'(done8), 64'd1);
      wait_idle("t1");

      go8(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1);
      wait_idle("t2a");
      go8(8'h10, 8'h10, 1'b1, 1'b1, 8'hFF, 1'b1);
      wait_idle("t2b");

      // start while busy must be ignored
      go8(8'h33, 8'h11, 1'b0, 1'b1, 8'h22, 1'b0);
      step();
      step();
      A8 = 8'hFF; B8 = 8'h00; start8 = 1'b1;
      step();
      start8 = 1'b0;
      wait_idle("t3");

      // reset in cycle 4 aborts the operation
      go8(8'h77, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", 64'(busy8), 64'd0);
      chk("abort_done", 64'(done8), 64'd0);
      chk("abort_diff", 64'(Diff8), 64'd0);
      chk("abort_borrow", 64'(Borrow8), 64'd0);
      repeat (10) step();
      go8(8'h80, 8'h7F, 1'b0, 1'b1, 8'h01, 1'b0);
      wait_idle("t4");

      // start held through the run into DONE: back-to-back second op
      begin
         exp_t e;
         A8 = 8'hC8; B8 = 8'h64; Bin8 = 1'b0; start8 = 1'b1;
         e.diff = 8'h64; e.bor = 1'b0; e.cyc = cyc + 9;
         q8.push_back(e);
         e.diff = 8'hFE; e.bor = 1'b1; e.cyc = cyc + 18;
         q8.push_back(e);
         repeat (5) step();
         A8 = 8'h03; B8 = 8'h05;
         repeat (5) step();
         start8 = 1'b0;
         step(); step();
         chk("diff_hold_run", 64'(Diff8), 64'h64);
         chk("busy_second_run", 64'(busy8), 64'd1);
         wait_idle("t5");
      end

      // WIDTH=1 exhaustive truth table, index {a,b,bin}
      tbl_d = 8'b1001_0110;
      tbl_b = 8'b1000_1110;
      for (int i = 0; i < 8; i++) begin
         idx = 3'(i);
         go1(idx[2], idx[1], idx[0], tbl_d[i], tbl_b[i]);
         wait_idle("w1");
      end

      chk("q8_drained", 64'(q8.size()), 64'd0);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Parametrised bit-serial subtractor, the multi-bit successor to the 1-bit half subtractor.
- Computes Diff = A - B - Bin (mod 2^WIDTH) and the final Borrow, LSB first, one bit per clock.
- Uses a single 1-bit full-subtractor cell plus a borrow flip-flop.
- Sits in the arithmetic library as an area-cheap subtractor for datapaths that can tolerate WIDTH-cycle latency, with a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when not busy.
- A  input  WIDTH  minuend; captured on an accepted start.
- B  input  WIDTH  subtrahend; captured on an accepted start.
- Bin  input  1  borrow-in for chaining; captured on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- Diff  output  WIDTH  registered result.
- Borrow  output  1  registered final borrow-out.

Behaviour:
- Clocking: one clock domain (clk). Reset is synchronous and active-high on rst.
- Reset values: busy=0, done=0, Diff=0, Borrow=0, state=IDLE, bit counter=0, internal shift regs=0. rst has priority over every other input.
- States:
  - IDLE: waiting for start.
  - RUN: processing bits.
  - DONE: one cycle, done=1.
- IDLE: start=1 at a clock edge captures A, B and Bin into shift regs and the borrow FF, clears the counter, and moves to RUN (busy=1 from the next cycle).
- RUN: each edge processes bit 0 of the shift regs:
  - d = a ^ b ^ bor
  - bor_next = (~a & b) | (~(a ^ b) & bor)
  - d is shifted into the MSB of the working result reg; the operand regs shift right; counter increments.
  - After the WIDTH-th edge, go to DONE. On that same edge, copy the working reg to Diff and bor_next to Borrow.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
  - start=1 in the DONE cycle is accepted, giving back-to-back operation with a single-cycle gap.
- Latency: start in cycle 0 gives busy in cycles 1..WIDTH and done in cycle WIDTH+1.
- Throughput: one result per WIDTH+1 cycles.
- Diff and Borrow hold the previous result through IDLE and RUN. They change only on the completion edge and are never partially updated.
- start while busy=1 is ignored, with no effect on the operation in progress. start held high is re-sampled only in IDLE/DONE.
- Arithmetic is unsigned modulo 2^WIDTH. Borrow=1 iff A < B + Bin as integers.
- WIDTH=1 with Bin=0 reproduces the half-subtractor truth table, with latency 2.
- rst mid-operation aborts the operation: outputs return to reset values and no done pulse is produced.
- Counter width is $clog2(WIDTH+1); it must not wrap before WIDTH.

Decomposition:
- Shared package arith_pkg:
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE (2-bit).
  - function for the counter width.
- Sub-module fs_bit: combinational 1-bit full subtractor with inputs a, b, bin and outputs d, bout. It is instantiated once, and also usable standalone.

Test Plan:
- WIDTH=8, A=0x5A, B=0x3C, Bin=0, start in cycle 0 -> busy in cycles 1..8; done in cycle 9 with Diff=0x1E, Borrow=0.
- WIDTH=8, A=0x00, B=0x01, Bin=0 -> Diff=0xFF, Borrow=1. Then A=0x10, B=0x10, Bin=1 -> Diff=0xFF, Borrow=1.
- start pulsed in cycle 3 while busy, with different A/B -> ignored; first result unchanged, exactly one done.
- rst asserted in cycle 4 of an operation -> next cycle busy=0, done=0, Diff=0, Borrow=0, no done. A fresh op with A=0x80, B=0x7F -> Diff=0x01, Borrow=0.
- start held in the DONE cycle with new operands 0x03-0x05 -> accepted; done in cycle 18 with Diff=0xFE, Borrow=1; Diff holds the prior value during RUN.
- WIDTH=1, exhaustive A, B, Bin (8 cases) -> matches the full-subtractor truth table; the Bin=0 rows match the half subtractor (D = A^B, Bo = ~A&B).
